// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one uart_tx core between NUM_REQ byte sources, one packet per grant.
// Define UART_ARB_HOLD_TIMEOUT_EN to force-release an owner that idles in HOLD.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 2,
  parameter int DATA_W       = 8,
  parameter int HOLD_TIMEOUT = 500000
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  input  logic [NUM_REQ-1:0]          req_last,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic [DATA_W-1:0]           tx_data,
  output logic                        tx_start,
  input  logic                        tx_busy,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id,
  output logic                        grant_active
`ifdef UART_ARB_HOLD_TIMEOUT_EN
  ,
  output logic                        timeout_flag
`endif
);

  localparam int IDW = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || HOLD_TIMEOUT < 2) begin : g_bad_cfg
    $error("uart_tx_arbiter: parameter out of range");
  end

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ISSUE     = 3'd1,
    S_WAIT_BUSY = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_HOLD      = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [IDW-1:0]      grant_q, grant_d;
  logic [IDW-1:0]      rr_q, rr_d;
  logic [IDW-1:0]      pick, nxt;
  logic                any;
  logic                active_q, active_d;
  logic                last_q, last_d;
  logic                start_q, start_d;
  logic [NUM_REQ-1:0]  ready_q, ready_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [DATA_W-1:0]   sel_data;
  logic                sel_last;

`ifdef UART_ARB_HOLD_TIMEOUT_EN
  localparam int TW = $clog2(HOLD_TIMEOUT + 1);
  logic [TW-1:0]       cnt_q, cnt_d;
  logic                tflag_q, tflag_d;
`endif

  // Lowest index at or above rr_q wins, wrapping.
  always_comb begin
    pick = '0;
    any  = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid[(int'(rr_q) + k) % NUM_REQ]) begin
        pick = IDW'((int'(rr_q) + k) % NUM_REQ);
        any  = 1'b1;
      end
    end
  end

  always_comb begin
    sel_data = req_data[grant_q*DATA_W +: DATA_W];
    sel_last = req_last[grant_q];
    nxt      = (grant_q == IDW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_d     = rr_q;
    active_d = active_q;
    last_d   = last_q;
    data_d   = data_q;
    ready_d  = '0;
    start_d  = |ready_q;
`ifdef UART_ARB_HOLD_TIMEOUT_EN
    cnt_d    = '0;
    tflag_d  = tflag_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (any) begin
          grant_d  = pick;
          active_d = 1'b1;
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (req_valid[grant_q] && !tx_busy) begin
          ready_d[grant_q] = 1'b1;
          data_d           = sel_data;
          last_d           = sel_last;
          state_d          = S_WAIT_BUSY;
        end
      end
      S_WAIT_BUSY: begin
        if (tx_busy) state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (!tx_busy) begin
          if (last_q) begin
            rr_d     = nxt;
            active_d = 1'b0;
            state_d  = S_IDLE;
          end else begin
            state_d  = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (req_valid[grant_q]) begin
          state_d = S_ISSUE;
        end
`ifdef UART_ARB_HOLD_TIMEOUT_EN
        else if (cnt_q == TW'(HOLD_TIMEOUT - 1)) begin
          rr_d     = nxt;
          active_d = 1'b0;
          tflag_d  = 1'b1;
          state_d  = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      grant_q  <= '0;
      rr_q     <= '0;
      active_q <= 1'b0;
      last_q   <= 1'b0;
      data_q   <= '0;
      ready_q  <= '0;
      start_q  <= 1'b0;
`ifdef UART_ARB_HOLD_TIMEOUT_EN
      cnt_q    <= '0;
      tflag_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_q     <= rr_d;
      active_q <= active_d;
      last_q   <= last_d;
      data_q   <= data_d;
      ready_q  <= ready_d;
      start_q  <= start_d;
`ifdef UART_ARB_HOLD_TIMEOUT_EN
      cnt_q    <= cnt_d;
      tflag_q  <= tflag_d;
`endif
    end
  end

  assign req_ready    = ready_q;
  assign tx_data      = data_q;
  assign tx_start     = start_q;
  assign grant_id     = grant_q;
  assign grant_active = active_q;
`ifdef UART_ARB_HOLD_TIMEOUT_EN
  assign timeout_flag = tflag_q;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: two queue-fed requesters and a uart_tx busy model.
// Define UART_ARB_HOLD_TIMEOUT_EN to include the HOLD timeout scenario.
module tb_uart_tx_arbiter;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ISSUE = 3'd1;
  localparam logic [2:0] ST_WDONE = 3'd3;
  localparam logic [2:0] ST_HOLD  = 3'd4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  req_valid = '0;
  logic [15:0] req_data = '0;
  logic [1:0]  req_last = '0;
  logic [1:0]  req_ready;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy;
  logic [0:0]  grant_id;
  logic        grant_active;
`ifdef UART_ARB_HOLD_TIMEOUT_EN
  logic        timeout_flag;
`endif

  logic        model_busy = 1'b0;
  logic        hold_busy = 1'b0;
  int          model_cnt = 0;

  logic [8:0]  rq0[$];
  logic [8:0]  rq1[$];
  int          txlog[$];
  int          rdylog[$];
  int          n_chk = 0;
  int          n_fail = 0;
  int          n_start = 0;
  int          cyc = 0;
  int          start_cyc = 0;
  int          v0_cyc = 0;
  int          base;
  int          h0;
  int          n;

  assign tx_busy = model_busy | hold_busy;

  uart_tx_arbiter #(
    .NUM_REQ(2),
    .DATA_W(8),
    .HOLD_TIMEOUT(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_last(req_last),
    .req_ready(req_ready),
    .tx_data(tx_data),
    .tx_start(tx_start),
    .tx_busy(tx_busy),
    .grant_id(grant_id),
    .grant_active(grant_active)
`ifdef UART_ARB_HOLD_TIMEOUT_EN
    ,
    .timeout_flag(timeout_flag)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // uart_tx model: busy one cycle after start, for 20 cycles
  always @(posedge clk) begin
    if (tx_start) begin
      model_busy <= 1'b1;
      model_cnt  <= 19;
    end else if (model_cnt != 0) begin
      model_cnt <= model_cnt - 1;
    end else begin
      model_busy <= 1'b0;
    end
  end

  // requesters: pop on ready, present queue head
  always @(negedge clk) begin
    if (req_ready[0] && rq0.size() > 0) void'(rq0.pop_front());
    if (req_ready[1] && rq1.size() > 0) void'(rq1.pop_front());
    if (!req_valid[0] && rq0.size() > 0) v0_cyc = cyc;
    req_valid[0] = (rq0.size() > 0);
    req_valid[1] = (rq1.size() > 0);
    if (rq0.size() > 0) {req_last[0], req_data[7:0]} = rq0[0];
    if (rq1.size() > 0) {req_last[1], req_data[15:8]} = rq1[0];
  end

  always @(negedge clk) begin
    if (!reset) begin
      n_chk++;
      assert ($onehot0(req_ready)) else begin
        n_fail++;
        $error("FAIL ready_onehot: got %b required at most one bit", req_ready);
      end
      if (tx_start) begin
        n_chk++;
        assert (tx_busy === 1'b0) else begin
          n_fail++;
          $error("FAIL start_busy: tx_busy %b with tx_start, required 0", tx_busy);
        end
        txlog.push_back(int'(tx_data));
        n_start++;
        start_cyc = cyc;
      end
      if (|req_ready) begin
        n_chk++;
        assert (req_ready[grant_id] === 1'b1) else begin
          n_fail++;
          $error("FAIL ready_owner: ready %b grant_id %0d", req_ready, grant_id);
        end
        rdylog.push_back(int'(grant_id));
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h required %0h", tag, got, exp);
    end
  endtask

  task automatic wait_done(input string tag);
    int k = 0;
    @(negedge clk);
    while ((rq0.size() != 0 || rq1.size() != 0 || grant_active !== 1'b0 ||
            tx_busy !== 1'b0) && k < 3000) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_done_timeout"}, k < 3000, 1);
  endtask

  task automatic wait_state(input string tag, input logic [2:0] st);
    int k = 0;
    while (dut.state_q !== st && k < 3000) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_state_timeout"}, k < 3000, 1);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", req_ready, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_tx_start", tx_start, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_grant_active", grant_active, 0);
    chk("rst_state", dut.state_q, ST_IDLE);
    chk("rst_rr", dut.rr_q, 0);
`ifdef UART_ARB_HOLD_TIMEOUT_EN
    chk("rst_timeout_flag", timeout_flag, 0);
`endif
    step();
    reset = 1'b0;

    // single byte
    step();
    rq0.push_back({1'b1, 8'h41});
    wait_done("single");
    chk("single_count", txlog.size(), 1);
    chk("single_data", txlog[0], 'h41);
    chk("single_ready0", rdylog.size(), 1);
    chk("single_ready_id", rdylog[0], 0);
    chk("single_starts", n_start, 1);
    chk("single_latency", start_cyc - v0_cyc, 3);
    chk("single_active", grant_active, 0);
    chk("single_rr", dut.rr_q, 1);

    // collision after reset
    do_reset();
    txlog.delete();
    rdylog.delete();
    step();
    rq0.push_back({1'b1, 8'h30});
    rq1.push_back({1'b1, 8'h31});
    wait_done("coll1");
    chk("coll1_first", txlog[0], 'h30);
    chk("coll1_second", txlog[1], 'h31);
    chk("coll1_rr", dut.rr_q, 0);
    step();
    rq0.push_back({1'b1, 8'h30});
    rq1.push_back({1'b1, 8'h31});
    wait_done("coll2");
    chk("coll2_first", txlog[2], 'h30);
    chk("coll2_second", txlog[3], 'h31);

    // alternation with both staying valid
    step();
    rq0.push_back({1'b1, 8'h30});
    rq0.push_back({1'b1, 8'h32});
    rq1.push_back({1'b1, 8'h31});
    rq1.push_back({1'b1, 8'h33});
    wait_done("alt");
    chk("alt_0", txlog[4], 'h30);
    chk("alt_1", txlog[5], 'h31);
    chk("alt_2", txlog[6], 'h32);
    chk("alt_3", txlog[7], 'h33);
    chk("alt_rdy", {rdylog[4][0], rdylog[5][0], rdylog[6][0], rdylog[7][0]}, 4'b0101);

    // packet lock
    base = txlog.size();
    step();
    rq0.push_back({1'b0, 8'h41});
    rq0.push_back({1'b0, 8'h42});
    rq0.push_back({1'b1, 8'h43});
    n = 0;
    while (txlog.size() < base + 1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("lock_first_start", txlog.size(), base + 1);
    step();
    rq1.push_back({1'b1, 8'h5a});
    wait_done("lock");
    chk("lock_A", txlog[base], 'h41);
    chk("lock_B", txlog[base+1], 'h42);
    chk("lock_C", txlog[base+2], 'h43);
    chk("lock_5A", txlog[base+3], 'h5a);
    chk("lock_rdy", {rdylog[base][0], rdylog[base+1][0], rdylog[base+2][0],
                     rdylog[base+3][0]}, 4'b0001);

    // busy respect
    base = txlog.size();
    n = n_start;
    step();
    hold_busy = 1'b1;
    rq1.push_back({1'b1, 8'h77});
    repeat (100) @(negedge clk);
    chk("busy_state", dut.state_q, ST_ISSUE);
    chk("busy_grant", grant_id, 1);
    chk("busy_no_start", n_start, n);
    chk("busy_no_ready", rdylog.size(), base);
    step();
    hold_busy = 1'b0;
    wait_done("busy");
    chk("busy_one_start", n_start, n + 1);
    chk("busy_data", txlog[base], 'h77);

    // reset during WAIT_DONE of byte 2 of 4
    base = txlog.size();
    step();
    rq0.push_back({1'b0, 8'h10});
    rq0.push_back({1'b0, 8'h11});
    rq0.push_back({1'b0, 8'h12});
    rq0.push_back({1'b1, 8'h13});
    n = 0;
    while (txlog.size() < base + 2 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("mid_byte2", txlog[base+1], 'h11);
    wait_state("mid", ST_WDONE);
    step();
    reset = 1'b1;
    rq0.delete();
    @(posedge clk);
    @(negedge clk);
    chk("mid_ready", req_ready, 0);
    chk("mid_tx_data", tx_data, 0);
    chk("mid_tx_start", tx_start, 0);
    chk("mid_grant_id", grant_id, 0);
    chk("mid_active", grant_active, 0);
    chk("mid_state", dut.state_q, ST_IDLE);
    chk("mid_rr", dut.rr_q, 0);
    step();
    reset = 1'b0;
    rq1.push_back({1'b1, 8'h5b});
    wait_done("mid_new");
    chk("mid_new_count", txlog.size(), base + 3);
    chk("mid_new_data", txlog[base+2], 'h5b);
    chk("mid_new_owner", rdylog[rdylog.size()-1], 1);

`ifdef UART_ARB_HOLD_TIMEOUT_EN
    // HOLD timeout
    base = txlog.size();
    step();
    rq0.push_back({1'b0, 8'h61});
    wait_state("to", ST_HOLD);
    h0 = cyc;
    step();
    rq1.push_back({1'b1, 8'h62});
    n = 0;
    while (grant_active !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("to_release_cycles", cyc - h0, 16);
    chk("to_flag", timeout_flag, 1);
    wait_done("to");
    chk("to_next_data", txlog[base+1], 'h62);
    chk("to_next_owner", rdylog[rdylog.size()-1], 1);
    chk("to_flag_sticky", timeout_flag, 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter core between NUM_REQ byte sources, for example the echo path and a status/banner message generator.
- Each grant lasts for a whole packet: a requester keeps the transmitter until it sends a byte flagged last.
- Packet-level arbitration is round-robin.
- Sits between the requesters and the uart_tx core, inside uart_echo, in the 50 MHz system clock domain.

Parameters:
- NUM_REQ, 2: number of requesters, range 2..8.
- DATA_W, 8: byte width.
- HOLD_TIMEOUT, 500000: idle cycles allowed in HOLD before forced release. Used only with the optional feature.

Ports:
- clk  in  1: system clock, 50 MHz.
- reset  in  1: synchronous, active-high reset.
- req_valid  in  NUM_REQ: per-requester byte available.
- req_data  in  NUM_REQ*DATA_W: per-requester byte. Requester i occupies bits [i*DATA_W +: DATA_W].
- req_last  in  NUM_REQ: current byte is the last byte of its packet.
- req_ready  out  NUM_REQ: one-cycle accept pulse to the granted requester.
- tx_data  out  DATA_W: byte presented to the uart_tx core.
- tx_start  out  1: one-cycle start pulse to the uart_tx core.
- tx_busy  in  1: uart_tx core is shifting a frame.
- grant_id  out  $clog2(NUM_REQ): index of the current owner.
- grant_active  out  1: a packet is in progress.

Behaviour:
- Reset values: req_ready=0, tx_data=0, tx_start=0, grant_id=0, grant_active=0, state=IDLE, rr_ptr=0. Reset asserted in any state returns to IDLE on the next edge and abandons any packet in progress. A frame already started inside the core is not aborted.
- A byte is transferred when req_valid[i] && req_ready[i]. Requesters must hold valid, data and last stable until ready.
- State IDLE:
  - If any req_valid is set, select the first set bit scanning upward from rr_ptr, wrapping modulo NUM_REQ.
  - Register grant_id and set grant_active=1. Go to ISSUE.
  - Selection takes 1 cycle.
- State ISSUE:
  - Entered with req_valid[grant_id]=1 and tx_busy=0. If tx_busy=1, stay in ISSUE.
  - In that cycle: req_ready[grant_id]=1, latch tx_data=req_data[grant_id], latch last_q=req_last[grant_id]. Pulse tx_start=1 on the following cycle. Go to WAIT_BUSY.
  - Latency from the first cycle of req_valid with the arbiter in IDLE to tx_start: 3 cycles.
- State WAIT_BUSY: wait for tx_busy=1, then go to WAIT_DONE. tx_data is held constant.
- State WAIT_DONE:
  - Wait for tx_busy=0.
  - If last_q=1: set rr_ptr=grant_id+1 (wrapping), grant_active=0, go to IDLE.
  - Otherwise go to HOLD.
- State HOLD:
  - Owner keeps the grant.
  - When req_valid[grant_id]=1, go to ISSUE.
  - Other requesters are ignored, even if valid.
- Simultaneous requests in IDLE: round-robin order. After requester k finishes a packet, requester k+1 mod NUM_REQ has priority.
- A requester that deasserts req_valid while waiting in IDLE loses nothing; it is re-evaluated every cycle.
- Only grant_id may receive req_ready. At most one req_ready bit is set in any cycle.
- tx_start is never asserted while tx_busy=1.
- Back-to-back packets from the same requester are allowed, but only when no other requester is valid.

Optional Feature:
- Macro: UART_ARB_HOLD_TIMEOUT_EN.
- Defined:
  - A counter increments every cycle in HOLD with req_valid[grant_id]=0 and clears on leaving HOLD.
  - When it reaches HOLD_TIMEOUT-1, the packet is force-ended: rr_ptr advances, grant_active=0, go to IDLE.
  - A sticky output timeout_flag (out, 1, reset 0) is set and cleared only by reset.
- Not defined:
  - HOLD waits indefinitely.
  - No counter, no timeout_flag port.
  - The HOLD_TIMEOUT parameter is unused.

Test Plan:
- Single byte: req0 sends 0x41 with last=1; the core model asserts busy 1 cycle after start for 20 cycles. Required: tx_start exactly once with tx_data=0x41, req_ready[0] one pulse, grant_active returns to 0, rr_ptr=1.
- Collision: req0 and req1 both valid in the same cycle after reset, each sending a 1-byte packet (0x30, 0x31). Required: 0x30 transmitted first, then 0x31. Then issue the same collision again. Required: order is 0x31 first this time? No; since rr_ptr=0 after req1 finishes, required order is 0x30 then 0x31 again, with strict alternation when both stay valid.
- Packet lock: req0 sends "ABC" with last only on 'C'; req1 becomes valid with 0x5A during the 'A' frame. Required: tx order 'A','B','C',0x5A, and no req_ready[1] before 'C' completes.
- Busy respect: tx_busy held high for 100 cycles when ISSUE is entered. Required: no tx_start and no req_ready until tx_busy falls, then one start.
- Reset mid-packet: assert reset during WAIT_DONE of byte 2 of a 4-byte packet. Required: all outputs at reset values the next cycle, state IDLE, and a new request from req1 granted normally.
- Timeout, with UART_ARB_HOLD_TIMEOUT_EN and HOLD_TIMEOUT=16: req0 sends a non-last byte then goes idle. Required: grant released exactly 16 cycles after entering HOLD, timeout_flag=1, and a pending req1 is served next.
